// File: rtl/dmem_vec_store_if.sv
// Store-request and debug-read bundle for dmem_vec_store.
// master = requester (bench / vector datapath), slave = the store block.
interface dmem_vec_store_if #(
    parameter int S = 32,
    parameter int V = 192
);
    localparam int LANES = V / S;

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high; the requester holds req_* stable until then.
    logic             req_valid;
    logic             req_ready;
    logic [S-1:0]     req_addr;
    logic [V-1:0]     req_data;
    logic [LANES-1:0] req_mask;
    logic             busy;
    logic             done;
    logic             err;
    logic [S-1:0]     dbg_addr;
    logic [S-1:0]     dbg_rd;

    modport master (
        output req_valid, req_addr, req_data, req_mask, dbg_addr,
        input  req_ready, busy, done, err, dbg_rd
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_mask, dbg_addr,
        output req_ready, busy, done, err, dbg_rd
    );
endinterface

// File: rtl/dmem_vec_store.sv
// Serializes one V-bit vector store into LANES word writes (one per clock)
// into a word-addressed image RAM, with a combinational debug read port.
module dmem_vec_store #(
    parameter int S    = 32,
    parameter int V    = 192,
    parameter int SIZE = 30015
) (
    input  logic                clk,
    input  logic                reset,
    dmem_vec_store_if.slave     bus,
    output logic [1:0]          fsm_state
);
    localparam int LANES  = V / S;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int IDX_W  = (SIZE > 1) ? $clog2(SIZE) : 1;

    localparam logic [S:0]        SIZE_EXT  = (S + 1)'(SIZE);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [S-1:0]      addr_q, addr_d;
    logic [V-1:0]      data_q, data_d;
    logic [LANES-1:0]  mask_q, mask_d;
    logic              err_q, err_d;

    logic              accept;
    logic [S:0]        lane_addr;
    logic              lane_in_range;
    logic              lane_en;
    logic [S-1:0]      lane_word;
    logic              we;
    logic [IDX_W-1:0]  wr_idx;
    logic [S:0]        dbg_ext;

    logic [S-1:0]      mem [SIZE];

    // Lane address is one bit wider than the bus so a wrap past 2^S still
    // compares as out of range instead of aliasing onto low memory.
    always_comb begin
        accept        = bus.req_valid && bus.req_ready;
        lane_addr     = {1'b0, addr_q} + (S + 1)'(lane_q);
        lane_in_range = lane_addr < SIZE_EXT;
        lane_en       = mask_q[lane_q];
        lane_word     = data_q[int'(lane_q) * S +: S];
        we            = (state_q == ST_WRITE) && lane_en && lane_in_range;
        wr_idx        = lane_addr[IDX_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mask_d  = mask_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = bus.req_addr;
                    data_d  = bus.req_data;
                    mask_d  = bus.req_mask;
                    err_d   = 1'b0;
                    lane_d  = '0;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (lane_en && !lane_in_range) begin
                    err_d = 1'b1;
                end
                // The mask never shortens the sweep: all LANES slots are visited.
                if (lane_q == LAST_LANE) begin
                    lane_d  = '0;
                    state_d = ST_DONE;
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lane_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
        end
    end

    // RAM contents survive reset; a reset edge only blocks the pending lane.
    always_ff @(posedge clk) begin
        if (we && !reset) begin
            mem[wr_idx] <= lane_word;
        end
    end

    always_comb begin
        dbg_ext       = {1'b0, bus.dbg_addr};
        bus.dbg_rd    = (dbg_ext < SIZE_EXT) ? mem[bus.dbg_addr[IDX_W-1:0]] : '0;
        bus.req_ready = (state_q == ST_IDLE) && !reset;
        bus.busy      = (state_q != ST_IDLE);
        bus.done      = (state_q == ST_DONE);
        bus.err       = err_q;
        fsm_state     = state_q;
    end
endmodule

// File: tb/tb_dmem_vec_store.sv
// Directed bench for dmem_vec_store: full/masked/range-edge stores,
// reset mid-operation and back-to-back accept spacing.
module tb_dmem_vec_store;
  localparam int S = 32;
  localparam int V = 192;
  localparam int SIZE = 30015;
  localparam int LANES = V / S;

  logic clk;
  logic reset;
  logic [1:0] fsm_state;
  int cyc;
  int checks;
  int errors;

  dmem_vec_store_if #(.S(S), .V(V)) bus ();

  dmem_vec_store #(.S(S), .V(V), .SIZE(SIZE)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .fsm_state(fsm_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [V-1:0] make_vec(input logic [S-1:0] base);
    logic [V-1:0] v;
    v = '0;
    for (int k = 0; k < LANES; k++) v[k*S +: S] = base + S'(k);
    return v;
  endfunction

  task automatic check_mem(input string tag, input logic [S-1:0] a, input logic [S-1:0] exp);
    bus.dbg_addr = a;
    #1;
    check(tag, 64'(bus.dbg_rd), 64'(exp));
  endtask

  // driver: one request, returns negedges from accept to done plus dbg samples
  task automatic do_store(input logic [S-1:0] a, input logic [V-1:0] d, input logic [LANES-1:0] m,
                          output int lat, output logic [S-1:0] rd1, output logic [S-1:0] rd2);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr = a;
    bus.req_data = d;
    bus.req_mask = m;
    bus.dbg_addr = a;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    rd1 = bus.dbg_rd;
    rd2 = '0;
    lat = 1;
    while (!bus.done && lat < 30) begin
      @(negedge clk);
      lat++;
      #1;
      if (lat == 2) rd2 = bus.dbg_rd;
    end
    @(negedge clk);
  endtask

  initial begin
    int lat;
    logic [S-1:0] rd1, rd2;
    int nacc;
    int acc_cyc[3];
    logic err_first;
    bit err_taken;
    bit done_seen;
    int n;

    checks = 0;
    errors = 0;
    cyc = 0;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.req_mask = '0;
    bus.dbg_addr = '0;

    // 1. reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready_low", 64'(bus.req_ready), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(bus.req_ready), 64'd1);
    check("idle_busy", 64'(bus.busy), 64'd0);
    check("idle_done", 64'(bus.done), 64'd0);
    check("idle_err", 64'(bus.err), 64'd0);
    check("idle_state", 64'(fsm_state), 64'd0);
    check_mem("idle_dbg0", 32'd0, 32'd0);

    // 2. full store
    do_store(32'd100, make_vec(32'hA000_0000), 6'b111111, lat, rd1, rd2);
    check("full_latency", 64'(lat), 64'd7);
    check("full_dbg_old", 64'(rd1), 64'd0);
    check("full_dbg_new", 64'(rd2), 64'hA000_0000);
    check("full_err", 64'(bus.err), 64'd0);
    check("full_ready_back", 64'(bus.req_ready), 64'd1);
    check_mem("full_m100", 32'd100, 32'hA000_0000);
    check_mem("full_m101", 32'd101, 32'hA000_0001);
    check_mem("full_m102", 32'd102, 32'hA000_0002);
    check_mem("full_m103", 32'd103, 32'hA000_0003);
    check_mem("full_m104", 32'd104, 32'hA000_0004);
    check_mem("full_m105", 32'd105, 32'hA000_0005);
    check_mem("full_m99", 32'd99, 32'd0);
    check_mem("full_m106", 32'd106, 32'd0);

    // 3. masked store
    do_store(32'd200, make_vec(32'hC000_0000), 6'b000101, lat, rd1, rd2);
    check("mask_latency", 64'(lat), 64'd7);
    check("mask_err", 64'(bus.err), 64'd0);
    check_mem("mask_m200", 32'd200, 32'hC000_0000);
    check_mem("mask_m201", 32'd201, 32'd0);
    check_mem("mask_m202", 32'd202, 32'hC000_0002);
    check_mem("mask_m203", 32'd203, 32'd0);
    check_mem("mask_m204", 32'd204, 32'd0);
    check_mem("mask_m205", 32'd205, 32'd0);

    // 4. range edge and address wrap
    do_store(32'd30012, make_vec(32'hD000_0000), 6'b111111, lat, rd1, rd2);
    check("edge_latency", 64'(lat), 64'd7);
    check("edge_err", 64'(bus.err), 64'd1);
    check_mem("edge_m30012", 32'd30012, 32'hD000_0000);
    check_mem("edge_m30013", 32'd30013, 32'hD000_0001);
    check_mem("edge_m30014", 32'd30014, 32'hD000_0002);
    check_mem("edge_dbg_oob", 32'd30015, 32'd0);
    do_store(32'hFFFF_FFFE, make_vec(32'hE000_0000), 6'b000001, lat, rd1, rd2);
    check("wrap_latency", 64'(lat), 64'd7);
    check("wrap_err", 64'(bus.err), 64'd1);
    check_mem("wrap_m0", 32'd0, 32'd0);
    check_mem("wrap_m1", 32'd1, 32'd0);

    // 6. back-to-back with valid held; fields scribbled while busy
    nacc = 0;
    err_taken = 1'b0;
    err_first = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr = 32'd300;
    bus.req_data = make_vec(32'hF000_0000);
    bus.req_mask = 6'b111111;
    for (int c = 0; c < 60 && nacc < 3; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.req_ready) begin
        acc_cyc[nacc] = cyc;
        nacc++;
      end else if (bus.done) begin
        bus.req_addr = 32'd300 + 32'(nacc * 10);
        bus.req_data = make_vec(32'hF000_0000 + 32'(nacc * 16));
        bus.req_mask = 6'b111111;
      end else begin
        if (!err_taken) begin
          err_first = bus.err;
          err_taken = 1'b1;
        end
        bus.req_valid = (nacc < 3);
        bus.req_addr = $urandom_range(0, 30000);
        bus.req_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        bus.req_mask = 6'($urandom_range(0, 63));
      end
    end
    n = 0;
    while (!bus.done && n < 30) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      n++;
    end
    check("b2b_last_done", 64'(bus.done), 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("b2b_accepts", 64'(nacc), 64'd3);
    check("b2b_gap01", 64'(acc_cyc[1] - acc_cyc[0]), 64'd8);
    check("b2b_gap12", 64'(acc_cyc[2] - acc_cyc[1]), 64'd8);
    check("b2b_err_cleared", 64'(err_first), 64'd0);
    check_mem("b2b_m300", 32'd300, 32'hF000_0000);
    check_mem("b2b_m305", 32'd305, 32'hF000_0005);
    check_mem("b2b_m310", 32'd310, 32'hF000_0010);
    check_mem("b2b_m315", 32'd315, 32'hF000_0015);
    check_mem("b2b_m320", 32'd320, 32'hF000_0020);
    check_mem("b2b_m325", 32'd325, 32'hF000_0025);

    // 5. reset during the third write cycle
    done_seen = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr = 32'd100;
    bus.req_data = make_vec(32'hB000_0000);
    bus.req_mask = 6'b111111;
    check("rst_mid_accept_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    done_seen |= bus.done;
    @(negedge clk);
    done_seen |= bus.done;
    @(negedge clk);
    done_seen |= bus.done;
    reset = 1'b1;
    #1;
    check("rst_mid_ready_low", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    done_seen |= bus.done;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      done_seen |= bus.done;
    end
    check("rst_mid_no_done", 64'(done_seen), 64'd0);
    check("rst_mid_ready", 64'(bus.req_ready), 64'd1);
    check("rst_mid_err", 64'(bus.err), 64'd0);
    check_mem("rst_mid_m100", 32'd100, 32'hB000_0000);
    check_mem("rst_mid_m101", 32'd101, 32'hB000_0001);
    check_mem("rst_mid_m102", 32'd102, 32'hA000_0002);
    check_mem("rst_mid_m103", 32'd103, 32'hA000_0003);
    check_mem("rst_mid_m104", 32'd104, 32'hA000_0004);
    check_mem("rst_mid_m105", 32'd105, 32'hA000_0005);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
